// File: rtl/vram_term_writer_if.sv
// ---------------------------------------------------------------------------
// vram_term_writer_if : byte-in handshake plus VRAM write port and cursor.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vram_term_writer_if;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic        o_we;
  logic [10:0] o_waddr;
  logic [7:0]  o_wdata;
  logic [5:0]  o_cur_col;
  logic [4:0]  o_cur_row;

  modport master (
    output i_data, i_valid,
    input  o_ready, o_we, o_waddr, o_wdata, o_cur_col, o_cur_row
  );

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_we, o_waddr, o_wdata, o_cur_col, o_cur_row
  );
endinterface

`default_nettype wire

// File: rtl/vram_term_writer.sv
// ---------------------------------------------------------------------------
// vram_term_writer : decodes received bytes into VRAM writes and cursor moves.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vram_term_writer #(
  parameter int         COLS  = 60,
  parameter int         ROWS  = 17,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  vram_term_writer_if.slave  bus
);

  localparam logic [1:0] S_CLR_SCREEN = 2'd0;
  localparam logic [1:0] S_IDLE       = 2'd1;
  localparam logic [1:0] S_WRITE      = 2'd2;
  localparam logic [1:0] S_CLR_LINE   = 2'd3;

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] ROW_END  = 5'(ROWS);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  logic [1:0]  state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  swc_q, swc_d;
  logic [4:0]  swr_q, swr_d;
  logic        adv_q, adv_d;
  logic        we_q, we_d;
  logic [10:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic        printable;
  logic [4:0]  row_next;

  assign accept    = ready_q & bus.i_valid;
  assign printable = (bus.i_data >= 8'h20) && (bus.i_data != 8'h7F);
  // Newline wraps to the top row; the screen never scrolls.
  assign row_next  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_CLR_SCREEN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLR_SCREEN: begin
        if (swr_q == ROW_END) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          if (printable)                                  state_d = S_WRITE;
          else if (bus.i_data == CH_LF)                   state_d = S_CLR_LINE;
          else if (bus.i_data == CH_BS && col_q != 6'd0)  state_d = S_WRITE;
          else if (bus.i_data == CH_FF)                   state_d = S_CLR_SCREEN;
        end
      end
      S_WRITE: begin
        state_d = (adv_q && col_q == LAST_COL) ? S_CLR_LINE : S_IDLE;
      end
      S_CLR_LINE: begin
        if (swc_q == LAST_COL) state_d = S_IDLE;
      end
      default: state_d = S_CLR_SCREEN;
    endcase
  end

  // Line sweeps preload their first write on entry so the busy time is exactly COLS cycles.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ready_d = (state_d == S_IDLE);
    col_d   = col_q;
    row_d   = row_q;
    swc_d   = swc_q;
    swr_d   = swr_q;
    adv_d   = adv_q;
    case (state_q)
      S_CLR_SCREEN: begin
        if (swr_q != ROW_END) begin
          we_d    = 1'b1;
          waddr_d = {swr_q, swc_q};
          wdata_d = BLANK;
          if (swc_q == LAST_COL) begin
            swc_d = 6'd0;
            swr_d = swr_q + 5'd1;
          end else begin
            swc_d = swc_q + 6'd1;
          end
        end else begin
          swc_d = 6'd0;
          swr_d = 5'd0;
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (printable) begin
            we_d    = 1'b1;
            waddr_d = {row_q, col_q};
            wdata_d = bus.i_data;
            adv_d   = 1'b1;
          end else if (bus.i_data == CH_LF) begin
            row_d   = row_next;
            we_d    = 1'b1;
            waddr_d = {row_next, 6'd0};
            wdata_d = BLANK;
            swc_d   = 6'd0;
          end else if (bus.i_data == CH_CR) begin
            col_d = 6'd0;
          end else if (bus.i_data == CH_BS) begin
            if (col_q != 6'd0) begin
              col_d   = col_q - 6'd1;
              we_d    = 1'b1;
              waddr_d = {row_q, col_q - 6'd1};
              wdata_d = BLANK;
              adv_d   = 1'b0;
            end
          end else if (bus.i_data == CH_FF) begin
            col_d = 6'd0;
            row_d = 5'd0;
            swc_d = 6'd0;
            swr_d = 5'd0;
          end
        end
      end
      S_WRITE: begin
        if (adv_q) begin
          if (col_q == LAST_COL) begin
            col_d   = 6'd0;
            row_d   = row_next;
            we_d    = 1'b1;
            waddr_d = {row_next, 6'd0};
            wdata_d = BLANK;
            swc_d   = 6'd0;
          end else begin
            col_d = col_q + 6'd1;
          end
        end
      end
      S_CLR_LINE: begin
        if (swc_q != LAST_COL) begin
          swc_d   = swc_q + 6'd1;
          we_d    = 1'b1;
          waddr_d = {row_q, swc_q + 6'd1};
          wdata_d = BLANK;
        end else begin
          swc_d = 6'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q   <= 6'd0;
      row_q   <= 5'd0;
      swc_q   <= 6'd0;
      swr_q   <= 5'd0;
      adv_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= 11'd0;
      wdata_q <= BLANK;
      ready_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      swc_q   <= swc_d;
      swr_q   <= swr_d;
      adv_q   <= adv_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_we      = we_q;
  assign bus.o_waddr   = waddr_q;
  assign bus.o_wdata   = wdata_q;
  assign bus.o_cur_col = col_q;
  assign bus.o_cur_row = row_q;

endmodule

`default_nettype wire
